// File: rtl/fetch_unit_if.sv
// fetch_unit_if: bus bundle for the instruction-fetch stage.
//   master : the fetch unit (drives imem request and decode-side outputs)
//   slave  : the environment (redirect source, instruction memory, decode)
// Signals:
//   redirect_valid/abs/base/imm  redirect request and target operands
//   imem_req/imem_addr           read request to synchronous instruction memory
//   imem_rdata                   read data, one cycle after imem_req
//   out_valid/out_ready          decode handshake; out_instr/out_pc payload
//   misalign_err                 sticky misaligned-redirect flag
interface fetch_unit_if #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 32
);
    logic                   redirect_valid;
    logic                   redirect_abs;
    logic [ADDR_WIDTH-1:0]  redirect_base;
    logic [INSTR_WIDTH-1:0] redirect_imm;
    logic                   imem_req;
    logic [ADDR_WIDTH-1:0]  imem_addr;
    logic [INSTR_WIDTH-1:0] imem_rdata;
    logic                   out_valid;
    logic                   out_ready;
    logic [INSTR_WIDTH-1:0] out_instr;
    logic [ADDR_WIDTH-1:0]  out_pc;
    logic                   misalign_err;

    modport master (
        input  redirect_valid, redirect_abs, redirect_base, redirect_imm,
        output imem_req, imem_addr,
        input  imem_rdata,
        output out_valid,
        input  out_ready,
        output out_instr, out_pc, misalign_err
    );

    modport slave (
        output redirect_valid, redirect_abs, redirect_base, redirect_imm,
        input  imem_req, imem_addr,
        output imem_rdata,
        input  out_valid,
        output out_ready,
        input  out_instr, out_pc, misalign_err
    );
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: sequential instruction-fetch front end.
// Owns the PC, issues reads to a synchronous-read instruction memory, buffers
// returned words in a DEPTH-entry FIFO and hands (instr, pc) to decode over a
// valid/ready handshake. Redirects (relative or absolute) flush everything
// buffered or in flight and restart fetching at the target.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous reset, active low
//   bus  - fetch_unit_if.master (redirect, imem, decode handshake, error flag)
module fetch_unit #(
    parameter int                    ADDR_WIDTH  = 16,
    parameter int                    INSTR_WIDTH = 32,
    parameter int                    DEPTH       = 2,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
    } entry_t;

    entry_t                mem [DEPTH];
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] inflight_pc;
    logic [CW-1:0]         count;
    logic [PW-1:0]         rd_ptr;
    logic [PW-1:0]         wr_ptr;
    logic                  inflight;
    logic                  kill;
    logic                  err;

    logic                  head_valid;
    logic                  pop;
    logic                  resp_valid;
    logic                  issue;
    logic                  misalign;
    logic [CW:0]           occupancy;
    logic [ADDR_WIDTH-1:0] target;

    // Only the low ADDR_WIDTH bits of the immediate take part in the target.
    logic unused_imm_hi;
    assign unused_imm_hi = ^bus.redirect_imm[INSTR_WIDTH-1:ADDR_WIDTH];

    assign head_valid = (count != '0);
    assign pop        = head_valid & bus.out_ready;
    assign resp_valid = inflight & ~kill;

    // Slots already owed to the FIFO (buffered + in flight) minus the one
    // leaving this cycle; a new request is allowed only if its response is
    // guaranteed a free slot, so the FIFO can never overflow.
    assign occupancy = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
    assign issue     = rst & ~bus.redirect_valid & (occupancy < (CW+1)'(DEPTH));

    always_comb begin
        target = bus.redirect_base + bus.redirect_imm[ADDR_WIDTH-1:0];
        if (bus.redirect_abs) target[0] = 1'b0;
        misalign    = (target[1:0] != 2'b00);
        target[1:0] = 2'b00;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc          <= RESET_PC;
            inflight_pc <= '0;
            count       <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            inflight    <= 1'b0;
            kill        <= 1'b0;
            err         <= 1'b0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            kill <= 1'b0;
            if (bus.redirect_valid) begin
                // A pop this cycle still completes; everything behind it is dropped.
                pc       <= target;
                count    <= '0;
                rd_ptr   <= '0;
                wr_ptr   <= '0;
                inflight <= 1'b0;
                kill     <= inflight;
                if (misalign) err <= 1'b1;
            end else begin
                inflight <= issue;
                if (issue) begin
                    pc          <= pc + ADDR_WIDTH'(4);
                    inflight_pc <= pc;
                end
                if (resp_valid) begin
                    mem[wr_ptr] <= '{instr: bus.imem_rdata, pc: inflight_pc};
                    wr_ptr      <= wr_ptr + PW'(1);
                end
                if (pop) rd_ptr <= rd_ptr + PW'(1);
                count <= count + CW'(resp_valid) - CW'(pop);
            end
        end
    end

    assign bus.imem_req     = issue;
    assign bus.imem_addr    = pc;
    assign bus.out_valid    = head_valid;
    assign bus.out_instr    = mem[rd_ptr].instr;
    assign bus.out_pc       = mem[rd_ptr].pc;
    assign bus.misalign_err = err;
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: self-checking bench for fetch_unit.
// Directed redirect table, hand-written multi-cycle sequences, and a random
// phase checked against a stream-level reference model.
module tb_fetch_unit;
    localparam int              AW       = 16;
    localparam int              IW       = 32;
    localparam int              DEPTH    = 2;
    localparam logic [AW-1:0]   RESET_PC = 16'h0000;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    fetch_unit_if #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) bus ();

    fetch_unit #(
        .ADDR_WIDTH (AW),
        .INSTR_WIDTH(IW),
        .DEPTH      (DEPTH),
        .RESET_PC   (RESET_PC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master)
    );

    int checks   = 0;
    int failures = 0;

    // Memory word: low half is the address, upper half a tag of it, so a
    // swapped or stale instr/pc pairing shows up.
    function automatic logic [31:0] word(input logic [15:0] a);
        return {a ^ 16'h5A3C, a};
    endfunction

    // Synchronous-read instruction memory.
    always @(posedge clk) begin
        if (bus.imem_req) bus.imem_rdata <= word(bus.imem_addr);
        else              bus.imem_rdata <= 32'hDEAD_BEEF;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // The FIFO must never be pushed while full.
    always @(negedge clk) begin
        if (rst && dut.resp_valid && !bus.redirect_valid &&
            !(bus.out_valid && bus.out_ready) && dut.count == 2'(DEPTH)) begin
            failures++;
            $display("FAIL push_full: push into full FIFO at %0t", $time);
        end
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // Hold reset two edges, release mid-cycle: returns in cycle C0.
    task automatic start(input logic ready);
        bus.redirect_valid = 1'b0;
        bus.redirect_abs   = 1'b0;
        bus.redirect_base  = '0;
        bus.redirect_imm   = '0;
        bus.out_ready      = ready;
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        #1;
    endtask

    // Redirect during the current cycle R; returns in R+1 with redirect dropped.
    task automatic redirect(input logic [15:0] base, input logic [31:0] imm, input logic abs);
        bus.redirect_valid = 1'b1;
        bus.redirect_base  = base;
        bus.redirect_imm   = imm;
        bus.redirect_abs   = abs;
        #1;
        chk("redir_no_req", 32'(bus.imem_req), 32'd0);
        step();
        bus.redirect_valid = 1'b0;
        #1;
    endtask

    typedef struct {
        logic [15:0] base;
        logic [31:0] imm;
        logic        abs;
        logic [15:0] exp_pc;
        logic        exp_err;
    } redir_vec_t;

    redir_vec_t vecs [7];

    // Reference target: plain modular arithmetic on the rules.
    function automatic int unsigned model_target(input logic [15:0] base, input logic [31:0] imm,
                                                 input logic abs, output logic mis);
        int unsigned s;
        s = (int'(base) + int'(imm[15:0])) % 65536;
        if (abs) s = s - (s % 2);
        mis = (s % 4) != 0;
        return s - (s % 4);
    endfunction

    initial begin
        logic [15:0] exp_pc;
        logic        exp_err;
        logic        mis;
        logic        rv;
        logic [15:0] rbase;
        logic [31:0] rimm;
        logic        rabs;
        int          idle;

        vecs[0] = '{16'h0010, 32'hFFFF_FFF8, 1'b0, 16'h0008, 1'b0};
        vecs[1] = '{16'h0101, 32'h0000_0003, 1'b1, 16'h0104, 1'b0};
        vecs[2] = '{16'h0100, 32'h0000_0002, 1'b0, 16'h0100, 1'b1};
        vecs[3] = '{16'hFFF0, 32'h0000_0020, 1'b0, 16'h0010, 1'b0};
        vecs[4] = '{16'h1237, 32'h0000_0000, 1'b1, 16'h1234, 1'b1};
        vecs[5] = '{16'h0003, 32'h0000_0001, 1'b1, 16'h0004, 1'b0};
        vecs[6] = '{16'h8000, 32'hFFFF_8000, 1'b0, 16'h0000, 1'b0};

        bus.redirect_valid = 1'b0;
        bus.redirect_abs   = 1'b0;
        bus.redirect_base  = '0;
        bus.redirect_imm   = '0;
        bus.out_ready      = 1'b1;

        // Reset state and streaming from RESET_PC.
        step();
        step();
        chk("rst_req",   32'(bus.imem_req),     32'd0);
        chk("rst_valid", 32'(bus.out_valid),    32'd0);
        chk("rst_pc",    32'(bus.out_pc),       32'd0);
        chk("rst_instr", bus.out_instr,         32'd0);
        chk("rst_err",   32'(bus.misalign_err), 32'd0);
        rst = 1'b1;
        #1;
        chk("c0_req",  32'(bus.imem_req),  32'd1);
        chk("c0_addr", 32'(bus.imem_addr), 32'(RESET_PC));
        step();
        chk("c1_valid", 32'(bus.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stream_valid", 32'(bus.out_valid), 32'd1);
            chk("stream_pc",    32'(bus.out_pc),    32'(RESET_PC + 16'(4 * i)));
            chk("stream_instr", bus.out_instr,      word(RESET_PC + 16'(4 * i)));
        end

        // Redirect table: each row from a fresh reset, redirect issued at pc 0x10
        // with a fetch in flight.
        for (int v = 0; v < 7; v++) begin
            start(1'b1);
            for (int i = 0; i < 4; i++) step();
            chk("pre_pc", 32'(bus.imem_addr), 32'h10);
            redirect(vecs[v].base, vecs[v].imm, vecs[v].abs);
            chk("r1_valid", 32'(bus.out_valid), 32'd0);
            chk("r1_req",   32'(bus.imem_req),  32'd1);
            chk("r1_addr",  32'(bus.imem_addr), 32'(vecs[v].exp_pc));
            step();
            chk("r2_valid", 32'(bus.out_valid), 32'd0);
            step();
            chk("r3_valid", 32'(bus.out_valid),    32'd1);
            chk("r3_pc",    32'(bus.out_pc),       32'(vecs[v].exp_pc));
            chk("r3_instr", bus.out_instr,         word(vecs[v].exp_pc));
            chk("r3_err",   32'(bus.misalign_err), 32'(vecs[v].exp_err));
            step();
            chk("r4_pc",    32'(bus.out_pc),       32'(vecs[v].exp_pc + 16'd4));
        end

        // Backpressure: hold ready low, FIFO saturates, then drains in order.
        start(1'b0);
        for (int i = 0; i < 10; i++) step();
        chk("bp_req",   32'(bus.imem_req),  32'd0);
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_head",  32'(bus.out_pc),    32'h0);
        chk("bp_count", 32'(dut.count),     32'(DEPTH));
        bus.out_ready = 1'b1;
        #1;
        chk("bp_resume_req", 32'(bus.imem_req), 32'd1);
        for (int i = 1; i < 4; i++) begin
            step();
            chk("bp_drain_valid", 32'(bus.out_valid), 32'd1);
            chk("bp_drain_pc",    32'(bus.out_pc),    32'(4 * i));
        end

        // Simultaneous pop and redirect: head consumed, entry behind it flushed.
        start(1'b1);
        step();
        bus.out_ready = 1'b0;
        redirect(16'h0020, 32'd0, 1'b0);
        for (int i = 0; i < 6; i++) step();
        chk("pr_head",  32'(bus.out_pc), 32'h20);
        chk("pr_count", 32'(dut.count),  32'd2);
        bus.out_ready = 1'b1;
        redirect(16'h0040, 32'd0, 1'b0);
        chk("pr_r1_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("pr_r2_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("pr_r3_pc", 32'(bus.out_pc), 32'h40);
        step();
        chk("pr_r4_pc", 32'(bus.out_pc), 32'h44);

        // PC wrap, then asynchronous reset between edges.
        start(1'b1);
        redirect(16'hFFFC, 32'd0, 1'b0);
        step();
        step();
        chk("wrap_last", 32'(bus.out_pc), 32'hFFFC);
        step();
        chk("wrap_zero", 32'(bus.out_pc), 32'h0000);
        step();
        chk("wrap_next", 32'(bus.out_pc), 32'h0004);
        #3;
        rst = 1'b0;
        #1;
        chk("arst_valid", 32'(bus.out_valid), 32'd0);
        chk("arst_req",   32'(bus.imem_req),  32'd0);
        chk("arst_pc",    32'(bus.out_pc),    32'd0);
        step();
        rst = 1'b1;
        #1;
        chk("arst_c0_addr", 32'(bus.imem_addr), 32'(RESET_PC));
        step();
        chk("arst_c1_valid", 32'(bus.out_valid), 32'd0);
        step();
        chk("arst_c2_pc",    32'(bus.out_pc),    32'(RESET_PC));
        chk("arst_c2_instr", bus.out_instr,      word(RESET_PC));

        // Random traffic against the stream model: popped PCs form a contiguous
        // +4 sequence that restarts at each redirect target.
        start(1'b1);
        exp_pc  = RESET_PC;
        exp_err = 1'b0;
        idle    = 0;
        for (int c = 0; c < 3000; c++) begin
            rv    = ($urandom_range(0, 19) == 0);
            rbase = 16'($urandom);
            rimm  = ($urandom_range(0, 1) == 0) ? $urandom : 32'($urandom_range(0, 7));
            rabs  = 1'($urandom_range(0, 1));
            bus.out_ready      = ($urandom_range(0, 9) < 7);
            bus.redirect_valid = rv;
            bus.redirect_base  = rbase;
            bus.redirect_imm   = rimm;
            bus.redirect_abs   = rabs;
            #1;
            chk("rnd_err", 32'(bus.misalign_err), 32'(exp_err));
            if (bus.out_valid && bus.out_ready) begin
                chk("rnd_pc",    32'(bus.out_pc), 32'(exp_pc));
                chk("rnd_instr", bus.out_instr,   word(exp_pc));
                exp_pc = exp_pc + 16'd4;
            end
            idle = bus.out_valid ? 0 : idle + 1;
            chk("rnd_bubble", 32'(idle <= 2), 32'd1);
            if (rv) begin
                exp_pc = 16'(model_target(rbase, rimm, rabs, mis));
                if (mis) exp_err = 1'b1;
                idle = 0;
            end
            step();
        end
        bus.redirect_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch stage that replaces the flat PC register / PC mux / increment logic with a sequential front end. It owns the PC, issues requests to a synchronous-read instruction memory, buffers returned words in a DEPTH-entry FIFO, and presents (instr, pc) pairs to decode over a valid/ready handshake. It also accepts branch/jump redirects in two modes, PC-relative and absolute, and flushes in-flight and buffered fetches on a redirect.

## Interface
- ADDR_WIDTH, 16, PC and instruction-memory byte-address width
- INSTR_WIDTH, 32, instruction and immediate width
- DEPTH, 2, FIFO entries; power of two, minimum 2
- RESET_PC, 0, PC loaded on reset; must be 4-byte aligned
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-low
- redirect_valid  input  1  redirect request this cycle
- redirect_abs  input  1  0: target = base + imm (branch/JAL); 1: target = (base + imm) with bit 0 cleared (JALR)
- redirect_base  input  ADDR_WIDTH  base address (instruction PC or rs1 low bits)
- redirect_imm  input  INSTR_WIDTH  sign-extended immediate; only [ADDR_WIDTH-1:0] is used
- imem_req  output  1  read request
- imem_addr  output  ADDR_WIDTH  read address, always equal to the current PC
- imem_rdata  input  INSTR_WIDTH  read data, valid exactly one cycle after imem_req
- out_valid  output  1  FIFO head is valid
- out_ready  input  1  decode accepts the head this cycle
- out_instr  output  INSTR_WIDTH  head instruction
- out_pc  output  ADDR_WIDTH  head PC
- misalign_err  output  1  sticky: a redirect target had bits [1:0] != 0

## Operation
- State: pc, FIFO (DEPTH × {instr, pc}), count (clog2(DEPTH+1) bits), inflight (1 bit), inflight_pc, kill (1 bit).
- pop = out_valid & out_ready.
- Issue condition: imem_req = !redirect_valid & (count + inflight − pop < DEPTH). On issue, pc <= pc + 4, inflight <= 1 and inflight_pc <= pc. Otherwise inflight <= 0.
- Response: when inflight is 1 and kill is 0, {imem_rdata, inflight_pc} is pushed into the FIFO. When kill is 1, the response is discarded.
- Redirect (highest priority):
  - target = redirect_base + redirect_imm[ADDR_WIDTH-1:0], modulo 2^ADDR_WIDTH.
  - If redirect_abs, bit 0 is cleared.
  - If target[1:0] != 0 after that, misalign_err is set and target[1:0] is forced to 0.
  - pc <= target; FIFO is cleared (count <= 0, pointers reset); kill <= inflight.
  - No request is issued that cycle.
  - A pop in the same cycle completes: decode has consumed the head, and the entries behind it are flushed.
- kill clears the cycle after it is used.
- Push and pop in the same cycle leave count unchanged. Push into a full FIFO is impossible by the issue rule; a bench assertion checks this.
- PC wraps modulo 2^ADDR_WIDTH; no error is raised on wrap.
- misalign_err clears only on reset.
- The FIFO holds no bypass path. out_* come from the registered head entry.

## Timing
- Reset (rst low, asynchronous): pc = RESET_PC, imem_req = 0, out_valid = 0, count = 0, inflight = 0, kill = 0, misalign_err = 0. out_instr and out_pc are 0.
- Reset mid-operation drops all buffered and in-flight data immediately. The response arriving after release is ignored because inflight = 0.
- First cycle after rst rises (C0): imem_req = 1 with imem_addr = RESET_PC. Response at C1; out_valid at C2.
- Redirect in cycle R: imem_req = 0 in R; request to target in R+1; out_valid with out_pc = target in R+3. out_valid is 0 in R+1 and R+2.
- Streaming with out_ready held high and DEPTH ≥ 2: one instruction per cycle in steady state, with PCs incrementing by 4.
- Backpressure: with out_ready low, at most DEPTH entries are accepted. imem_req then stays low until a pop. Throughput resumes without a bubble on the cycle after out_ready rises.

## Test plan
- Reset/stream: RESET_PC = 0x0000, out_ready = 1, memory word = address → out_pc/out_instr = 0x0000, 0x0004, 0x0008, … on consecutive cycles from C2; imem_req = 0 while rst is low.
- Backpressure: DEPTH = 2, hold out_ready = 0 for 10 cycles → count saturates at 2, imem_req low, no lost or duplicated PCs after release; order is 0x0, 0x4, 0x8.
- Relative redirect with in-flight fetch: redirect at pc 0x0010, base = 0x0010, imm = 0xFFFFFFF8 → in-flight response dropped, FIFO emptied, next out_pc = 0x0008 exactly 3 cycles later.
- Absolute redirect: base = 0x0101, imm = 0x00000003, abs = 1 → target 0x0104, misalign_err stays 0. Then base = 0x0100, imm = 2, abs = 0 → misalign_err = 1, next out_pc = 0x0100.
- Simultaneous pop and redirect: FIFO holds 0x20 and 0x24, out_ready = 1, redirect to 0x40 → 0x20 consumed, 0x24 never presented, next out_pc = 0x40.
- Wrap and async reset: start at 0xFFFC → next PC is 0x0000. Assert rst mid-stream between clock edges → out_valid drops immediately; restart from RESET_PC.
